// File: rtl/operand_loader.sv
// Captures two 8-bit operands from switch inputs on debounced-free async strobe
// edges and presents them as a valid pair to a downstream adder.
module operand_loader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load_strobe,
  input  logic       clear,
  input  logic       op_ready,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       op_valid,
  output logic [1:0] state,
  output logic       overrun
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    VALID   = 2'b10,
    UNUSED  = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;
  logic                   load_ev_s;

  state_t     state_r, next_state_s;
  logic [7:0] op_a_r, op_b_r, op_a_next_s, op_b_next_s;
  logic       op_valid_r, overrun_r, overrun_next_s;

  // Synchronizer chain plus edge-detect flop; preset high so a strobe held
  // across reset release produces no event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      dly_r  <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], load_strobe};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign load_ev_s = sync_r[SYNC_STAGES-1] & ~dly_r;

  // Next-state and operand update logic.
  always_comb begin
    next_state_s   = state_r;
    op_a_next_s    = op_a_r;
    op_b_next_s    = op_b_r;
    overrun_next_s = overrun_r;
    if (clear) begin
      next_state_s   = WAIT_A;
      op_a_next_s    = 8'h00;
      op_b_next_s    = 8'h00;
      overrun_next_s = 1'b0;
    end else begin
      case (state_r)
        WAIT_A: begin
          if (load_ev_s) begin
            op_a_next_s  = data_in;
            next_state_s = WAIT_B;
          end else begin
            next_state_s = WAIT_A;
          end
        end
        WAIT_B: begin
          if (load_ev_s) begin
            op_b_next_s  = data_in;
            next_state_s = VALID;
          end else begin
            next_state_s = WAIT_B;
          end
        end
        VALID: begin
          if (op_ready) begin
            // Handshake and a new load may coincide: start the next pair.
            if (load_ev_s) begin
              op_a_next_s  = data_in;
              next_state_s = WAIT_B;
            end else begin
              next_state_s = WAIT_A;
            end
          end else if (load_ev_s) begin
            overrun_next_s = 1'b1;
          end else begin
            next_state_s = VALID;
          end
        end
        default: begin
          next_state_s = WAIT_A;
        end
      endcase
    end
  end

  // State, operand and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= WAIT_A;
      op_a_r     <= 8'h00;
      op_b_r     <= 8'h00;
      op_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      op_a_r     <= op_a_next_s;
      op_b_r     <= op_b_next_s;
      op_valid_r <= (next_state_s == VALID);
      overrun_r  <= overrun_next_s;
    end
  end

  assign op_a     = op_a_r;
  assign op_b     = op_b_r;
  assign op_valid = op_valid_r;
  assign state    = state_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader at default SYNC_STAGES.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       load_strobe;
  logic       clear;
  logic       op_ready;
  logic [7:0] op_a, op_b;
  logic       op_valid, overrun;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  operand_loader dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_strobe(load_strobe),
    .clear(clear), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .state(state), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe high 4 cycles (capture lands on 3rd edge), then low 4 cycles.
  task automatic pulse(input logic [7:0] d);
    data_in = d;
    load_strobe = 1'b1;
    cyc(4);
    load_strobe = 1'b0;
    cyc(4);
  endtask

  initial begin
    rst = 1'b1; data_in = 8'h00; load_strobe = 1'b0; clear = 1'b0; op_ready = 1'b0;
    #1;
    chk("rst_state", {6'd0, state}, 8'h00);
    chk("rst_op_a", op_a, 8'h00);
    chk("rst_op_b", op_b, 8'h00);
    chk("rst_valid", {7'd0, op_valid}, 8'h00);
    chk("rst_overrun", {7'd0, overrun}, 8'h00);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Latency: capture exactly on the third edge after the strobe rises.
    data_in = 8'h2A;
    load_strobe = 1'b1;
    cyc(2);
    chk("lat_edge2_op_a", op_a, 8'h00);
    cyc(1);
    chk("lat_edge3_op_a", op_a, 8'h2A);
    chk("lat_edge3_state", {6'd0, state}, 8'h01);
    cyc(1);
    load_strobe = 1'b0;
    cyc(4);
    pulse(8'h15);
    chk("pair_valid", {7'd0, op_valid}, 8'h01);
    chk("pair_op_a", op_a, 8'h2A);
    chk("pair_op_b", op_b, 8'h15);
    chk("pair_state", {6'd0, state}, 8'h02);

    // Handshake with no load.
    op_ready = 1'b1;
    cyc(1);
    op_ready = 1'b0;
    chk("hs_valid", {7'd0, op_valid}, 8'h00);
    chk("hs_state", {6'd0, state}, 8'h00);
    chk("hs_op_a", op_a, 8'h2A);

    // Overrun while stalled, then clear.
    pulse(8'h2A);
    pulse(8'h15);
    pulse(8'hFF);
    chk("ovr_op_a", op_a, 8'h2A);
    chk("ovr_op_b", op_b, 8'h15);
    chk("ovr_flag", {7'd0, overrun}, 8'h01);
    chk("ovr_state", {6'd0, state}, 8'h02);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_overrun", {7'd0, overrun}, 8'h00);
    chk("clr_op_a", op_a, 8'h00);
    chk("clr_op_b", op_b, 8'h00);
    chk("clr_valid", {7'd0, op_valid}, 8'h00);
    chk("clr_state", {6'd0, state}, 8'h00);

    // Load event coincident with handshake.
    pulse(8'h11);
    pulse(8'h22);
    chk("co_pre_state", {6'd0, state}, 8'h02);
    data_in = 8'h80;
    load_strobe = 1'b1;
    cyc(2);
    op_ready = 1'b1;
    cyc(1);
    op_ready = 1'b0;
    chk("co_op_a", op_a, 8'h80);
    chk("co_state", {6'd0, state}, 8'h01);
    chk("co_overrun", {7'd0, overrun}, 8'h00);
    chk("co_valid", {7'd0, op_valid}, 8'h00);
    cyc(1);
    load_strobe = 1'b0;
    cyc(4);

    // Strobe held high across reset release.
    data_in = 8'h5C;
    load_strobe = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("hold_op_a", op_a, 8'h00);
    chk("hold_state", {6'd0, state}, 8'h00);
    load_strobe = 1'b0;
    cyc(4);
    pulse(8'h5C);
    chk("rearm_op_a", op_a, 8'h5C);
    chk("rearm_state", {6'd0, state}, 8'h01);

    // Asynchronous reset mid-sequence.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    pulse(8'h33);
    chk("mid_pre_op_a", op_a, 8'h33);
    #2;
    rst = 1'b1;
    #1;
    chk("async_op_a", op_a, 8'h00);
    chk("async_state", {6'd0, state}, 8'h00);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on load_strobe (legal range 2..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data_in  input  8  operand value presented by the user switches.
REQ-005 SHALL have port load_strobe  input  1  asynchronous load button; each rising edge requests one operand capture.
REQ-006 SHALL have port clear  input  1  synchronous abort; returns block to empty state.
REQ-007 SHALL have port op_ready  input  1  downstream 8-bit adder accepts the operand pair.
REQ-008 SHALL have port op_a  output  8  first captured operand.
REQ-009 SHALL have port op_b  output  8  second captured operand.
REQ-010 SHALL have port op_valid  output  1  op_a/op_b form a complete pair for the adder.
REQ-011 SHALL have port state  output  2  current FSM state encoding (debug/status LEDs).
REQ-012 SHALL have port overrun  output  1  sticky flag: a load request was dropped.

Function
REQ-013 SHALL pass load_strobe through a SYNC_STAGES-deep flop chain, then compare it against a one-flop delayed copy to form a one-cycle load event on a 0->1 transition.
REQ-014 SHALL produce the load event exactly SYNC_STAGES+1 clk edges after load_strobe rises (setup met); data_in SHALL be sampled on the load-event cycle.
REQ-015 SHALL implement FSM states WAIT_A=2'b00, WAIT_B=2'b01, VALID=2'b10; 2'b11 unreachable, and if entered SHALL go to WAIT_A next cycle.
REQ-016 In WAIT_A, on load event: op_a <= data_in, next state WAIT_B.
REQ-017 In WAIT_B, on load event: op_b <= data_in, next state VALID.
REQ-018 op_valid SHALL be a registered output, high exactly while state==VALID (first high one cycle after the op_b capture).
REQ-019 In VALID, op_a and op_b SHALL be held stable until the handshake (op_valid & op_ready) completes.
REQ-020 In VALID with op_ready=1 and no load event: next state WAIT_A; op_a/op_b retain their values.
REQ-021 In VALID with op_ready=1 and a load event in the same cycle: handshake completes and op_a <= data_in, next state WAIT_B (no loss, no overrun).
REQ-022 In VALID with op_ready=0 and a load event: event dropped, operands unchanged, overrun <= 1.
REQ-023 op_ready SHALL be ignored in WAIT_A and WAIT_B.
REQ-024 clear=1 SHALL have priority over all events: next state WAIT_A, op_valid <= 0, overrun <= 0, op_a <= 0, op_b <= 0; a coincident load event is discarded.
REQ-025 overrun SHALL stay set until clear or rst.
REQ-026 Operand registers SHALL hold 8-bit unsigned values unmodified; no arithmetic is performed in this block.

Reset
REQ-027 While rst=1: state=WAIT_A, op_a=0, op_b=0, op_valid=0, overrun=0, effective immediately without a clock.
REQ-028 rst SHALL preset every synchronizer flop and the edge-detect flop to 1, so a strobe held high through reset release yields no event until it falls and rises again.
REQ-029 rst asserted mid-sequence (WAIT_B or VALID) SHALL discard all captured operands and any in-flight synchronized edge.

Verification
REQ-030 Bench SHALL check: data_in=0x2A, strobe pulse; data_in=0x15, strobe pulse; op_ready=0 -> op_valid=1, op_a=0x2A, op_b=0x15, state=2'b10; strobe edge to op_a update takes exactly 3 cycles at default SYNC_STAGES.
REQ-031 Bench SHALL check: pair in VALID, op_ready=1 for one cycle -> op_valid=0 and state=2'b00 next cycle, op_a=0x2A retained.
REQ-032 Bench SHALL check: in VALID with op_ready=0, extra strobe with data_in=0xFF -> operands unchanged, overrun=1; then clear -> overrun=0, all outputs 0.
REQ-033 Bench SHALL check: load event coincident with op_ready=1 in VALID, data_in=0x80 -> op_a=0x80, state=2'b01, overrun=0.
REQ-034 Bench SHALL check: strobe held high across rst deassertion -> no capture; strobe low then high -> one capture into op_a.
REQ-035 Bench SHALL check: rst asserted asynchronously in WAIT_B after op_a=0x33 -> op_a=0 before the next clk edge, state=2'b00.
